// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller: FSM encoding
// and the width of one adder slice.
package nibble_serial_add_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_add_ctrl_adder.sv
// Purely combinational 4-bit full adder, shared by every nibble position.
module nibble_adder4
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Sequences one 4-bit adder over NIBBLES nibbles, LSB nibble first, with the
// carry held in a register; valid/ready on both sides, result held until taken.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NIB_W*NIBBLES-1:0] in_a,
    input  logic [NIB_W*NIBBLES-1:0] in_b,
    input  logic                   in_cin,
    input  logic                   abort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NIB_W*NIBBLES-1:0] out_sum,
    output logic                   out_cout,
    output logic                   out_ovf,
    output logic                   busy
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [NIB_W-1:0]   w_nib_a;
    logic [NIB_W-1:0]   w_nib_b;
    logic [NIB_W-1:0]   w_nib_sum;
    logic               w_nib_cout;
    logic               w_c_msb;

    assign w_nib_a = r_a[r_idx*NIB_W +: NIB_W];
    assign w_nib_b = r_b[r_idx*NIB_W +: NIB_W];

    nibble_adder4 u_adder (
        .a    (w_nib_a),
        .b    (w_nib_b),
        .cin  (r_carry),
        .sum  (w_nib_sum),
        .cout (w_nib_cout)
    );

    // Carry into the top bit of the current nibble, recovered from its sum bit.
    assign w_c_msb = w_nib_sum[NIB_W-1] ^ w_nib_a[NIB_W-1] ^ w_nib_b[NIB_W-1];

    // Controller FSM; owns every register including the registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_carry    <= in_cin;
                        r_idx      <= '0;
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state    <= ST_IDLE;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_sum[r_idx*NIB_W +: NIB_W] <= w_nib_sum;
                        r_carry <= w_nib_cout;
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == LAST_IDX) begin
                            r_ovf       <= w_c_msb ^ w_nib_cout;
                            r_state     <= ST_DONE;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_sum   = r_sum;
    assign out_cout  = r_carry;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (NIBBLES=4): corner vector
// table, hand-written multi-cycle sequences and randomized trials vs a model.
module tb_nibble_serial_add_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         abort = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    int total = 0;
    int bad   = 0;

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic, overflow from operand/result sign bits.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] s;
        logic       ovf;
        s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {ovf, s};
    endfunction

    task automatic wait_valid();
        int lat;
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, NIBBLES);
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int n;
        n = 0;
        while (!in_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_launch", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        wait_valid();
    endtask

    task automatic check_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W+1:0] r;
        r = ref_add(a, b, c);
        check("out_valid", out_valid, 1);
        check("out_sum", out_sum, r[W-1:0]);
        check("out_cout", out_cout, r[W]);
        check("out_ovf", out_ovf, r[W+1]);
    endtask

    task automatic drain(input int hold);
        logic [W-1:0] s;
        s = out_sum;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, s);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_dropped", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[7] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", out_sum, 0);
        check("rst_cout", out_cout, 0);
        check("rst_ovf", out_ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Corner vector table with known constants.
        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].cin);
            check("tbl_valid", out_valid, 1);
            check("tbl_sum", out_sum, vecs[i].sum);
            check("tbl_cout", out_cout, vecs[i].cout);
            check("tbl_ovf", out_ovf, vecs[i].ovf);
            drain(0);
        end

        // Backpressure with a new request pending the whole time.
        launch(16'h1111, 16'h2222, 1'b0);
        check_result(16'h1111, 16'h2222, 1'b0);
        in_valid = 1'b1;
        in_a     = 16'hAAAA;
        in_b     = 16'h5555;
        in_cin   = 1'b1;
        drain(10);
        @(negedge clk);
        in_valid = 1'b0;
        check("bubble_accept_ready", in_ready, 0);
        check("bubble_accept_busy", busy, 1);
        wait_valid();
        check_result(16'hAAAA, 16'h5555, 1'b1);
        drain(0);

        // Abort during the second RUN cycle.
        in_valid = 1'b1;
        in_a     = 16'h3333;
        in_b     = 16'h4444;
        in_cin   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        for (int i = 0; i < 6; i++) begin
            check("abort_no_valid", out_valid, 0);
            @(negedge clk);
        end
        launch(16'h0F0F, 16'h00F1, 1'b0);
        check("post_abort_sum", out_sum, 16'h1000);
        check("post_abort_cout", out_cout, 0);
        drain(0);

        // Asynchronous reset in the third RUN cycle.
        in_valid = 1'b1;
        in_a     = 16'hFFFF;
        in_b     = 16'hFFFF;
        in_cin   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_valid", out_valid, 0);
        check("arst_sum", out_sum, 0);
        check("arst_cout", out_cout, 0);
        check("arst_ovf", out_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_release_ready", in_ready, 1);
        launch(16'h0F0F, 16'h00F1, 1'b1);
        check_result(16'h0F0F, 16'h00F1, 1'b1);
        drain(1);

        // Randomized trials with random consumer stall.
        for (int t = 0; t < 1000; t++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         c;
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom_range(0, 1));
            launch(a, b, c);
            check_result(a, b, c);
            drain(int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
